// File: rtl/node_route_sequencer.sv
// Route sequencer between the line follower and the motor PWM stage.
// Passes line-follower commands through, and runs a centre-and-pivot turn at each node per the route table.
//
// state     | meaning
// IDLE      | motors off, waiting for start
// FOLLOW    | line-follower commands passed through, watching for nodes
// CENTER    | driving forward to centre the chassis over the node
// PIVOT_OFF | pivoting until the middle sensor leaves the line
// PIVOT_ON  | pivoting until the middle sensor reacquires a line
// FINISH    | route complete, one-cycle done pulse
// FAULT     | pivot timed out, motors off until the next start
module node_route_sequencer #(
    parameter int          DEPTH         = 16,
    parameter int          CENTER_CYCLES = 312500,
    parameter int          TURN_TIMEOUT  = 3125000,
    parameter logic [11:0] THRESH_HI     = 12'd1000,
    parameter logic [11:0] THRESH_LO     = 12'd200,
    parameter logic [3:0]  PIVOT_DC      = 4'd8,
    parameter logic [3:0]  CENTER_DC     = 4'd9
) (
    input  logic        clk_3125KHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic        node_flag,
    input  logic [11:0] middle,
    input  logic        lf_m1_a,
    input  logic        lf_m1_b,
    input  logic        lf_m2_a,
    input  logic        lf_m2_b,
    input  logic [3:0]  lf_dc1,
    input  logic [3:0]  lf_dc2,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [1:0]  cfg_cmd,
    input  logic [4:0]  cfg_len,
    output logic        m1_a,
    output logic        m1_b,
    output logic        m2_a,
    output logic        m2_b,
    output logic [3:0]  dc1,
    output logic [3:0]  dc2,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [3:0]  step
);

    typedef enum logic [2:0] {
        S_IDLE, S_FOLLOW, S_CENTER, S_PIVOT_OFF, S_PIVOT_ON, S_FINISH, S_FAULT
    } state_t;

    localparam logic [1:0]  CMD_STRAIGHT = 2'b00;
    localparam logic [1:0]  CMD_LEFT     = 2'b01;
    localparam logic [1:0]  CMD_RIGHT    = 2'b10;
    localparam logic [1:0]  CMD_STOP     = 2'b11;
    localparam logic [23:0] CENTER_TC    = 24'(CENTER_CYCLES - 1);
    localparam logic [23:0] TURN_TC      = 24'(TURN_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [4:0]  step_q, step_d;
    logic [4:0]  len_q, len_d;
    logic        dir_right_q, dir_right_d;
    logic        node_prev_q;
    logic [1:0]  route_q [DEPTH];

    logic        node_evt;
    logic [4:0]  len_clamped;
    logic        m1_a_d, m1_b_d, m2_a_d, m2_b_d, busy_d;
    logic [3:0]  dc1_d, dc2_d;

    assign node_evt    = node_flag & ~node_prev_q;
    assign len_clamped = (cfg_len > 5'd16) ? 5'd16 : cfg_len;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
        step_d      = step_q;
        len_d       = len_q;
        dir_right_d = dir_right_q;
        case (state_q)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    len_d   = len_clamped;
                    step_d  = 5'd0;
                    state_d = (len_clamped == 5'd0) ? S_FINISH : S_FOLLOW;
                end
            end
            S_FOLLOW: begin
                if (node_evt) begin
                    if (step_q == len_q) begin
                        state_d = S_FINISH;
                    end else begin
                        case (route_q[step_q[3:0]])
                            CMD_STRAIGHT: step_d = step_q + 5'd1;
                            CMD_LEFT, CMD_RIGHT: begin
                                step_d      = step_q + 5'd1;
                                cnt_d       = 24'd0;
                                dir_right_d = (route_q[step_q[3:0]] == CMD_RIGHT);
                                state_d     = S_CENTER;
                            end
                            default: state_d = S_FINISH;
                        endcase
                    end
                end
            end
            S_CENTER: begin
                if (cnt_q == CENTER_TC) begin
                    cnt_d   = 24'd0;
                    state_d = S_PIVOT_OFF;
                end
            end
            S_PIVOT_OFF: begin
                if (cnt_q == TURN_TC)       state_d = S_FAULT;
                else if (middle < THRESH_LO) state_d = S_PIVOT_ON;
            end
            S_PIVOT_ON: begin
                if (cnt_q == TURN_TC)       state_d = S_FAULT;
                else if (middle > THRESH_HI) state_d = S_FOLLOW;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        m1_a_d = 1'b0;
        m1_b_d = 1'b0;
        m2_a_d = 1'b0;
        m2_b_d = 1'b0;
        dc1_d  = 4'd0;
        dc2_d  = 4'd0;
        busy_d = 1'b0;
        case (state_d)
            S_FOLLOW: begin
                {m1_a_d, m1_b_d, m2_a_d, m2_b_d} = {lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b};
                dc1_d  = lf_dc1;
                dc2_d  = lf_dc2;
                busy_d = 1'b1;
            end
            S_CENTER: begin
                {m1_a_d, m1_b_d, m2_a_d, m2_b_d} = 4'b1010;
                dc1_d  = CENTER_DC;
                dc2_d  = CENTER_DC;
                busy_d = 1'b1;
            end
            S_PIVOT_OFF, S_PIVOT_ON: begin
                {m1_a_d, m1_b_d, m2_a_d, m2_b_d} = dir_right_d ? 4'b1001 : 4'b0110;
                dc1_d  = PIVOT_DC;
                dc2_d  = PIVOT_DC;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 24'd0;
            step_q      <= 5'd0;
            len_q       <= 5'd0;
            dir_right_q <= 1'b0;
            node_prev_q <= 1'b0;
            m1_a        <= 1'b0;
            m1_b        <= 1'b0;
            m2_a        <= 1'b0;
            m2_b        <= 1'b0;
            dc1         <= 4'd0;
            dc2         <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) route_q[i] <= CMD_STOP;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            len_q       <= len_d;
            dir_right_q <= dir_right_d;
            node_prev_q <= node_flag;
            m1_a        <= m1_a_d;
            m1_b        <= m1_b_d;
            m2_a        <= m2_a_d;
            m2_b        <= m2_b_d;
            dc1         <= dc1_d;
            dc2         <= dc2_d;
            busy        <= busy_d;
            done        <= (state_d == S_FINISH);
            fault       <= (state_d == S_FAULT);
            if (cfg_we && !busy) route_q[cfg_addr] <= cfg_cmd;
        end
    end

    assign step = step_q[3:0];

endmodule

// File: tb/tb_node_route_sequencer.sv
// Directed bench for node_route_sequencer with shortened centring and pivot timeouts.
module tb_node_route_sequencer;

    localparam int CC = 20;
    localparam int TT = 50;
    localparam logic [1:0] STRAIGHT = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, STOP = 2'b11;
    localparam logic [11:0] LF_BUNDLE     = 12'b1001_1100_0111;
    localparam logic [11:0] CENTER_BUNDLE = 12'b1010_1001_1001;
    localparam logic [11:0] LEFT_BUNDLE   = 12'b0110_1000_1000;
    localparam logic [11:0] RIGHT_BUNDLE  = 12'b1001_1000_1000;

    logic        clk_3125KHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        node_flag = 1'b0;
    logic [11:0] middle = 12'd1500;
    logic        lf_m1_a = 1'b1, lf_m1_b = 1'b0, lf_m2_a = 1'b0, lf_m2_b = 1'b1;
    logic [3:0]  lf_dc1 = 4'd12, lf_dc2 = 4'd7;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [1:0]  cfg_cmd = 2'b00;
    logic [4:0]  cfg_len = 5'd0;
    logic        m1_a, m1_b, m2_a, m2_b, busy, done, fault;
    logic [3:0]  dc1, dc2, step;
    logic [11:0] bundle;

    int checks = 0;
    int errors = 0;

    assign bundle = {m1_a, m1_b, m2_a, m2_b, dc1, dc2};

    node_route_sequencer #(.CENTER_CYCLES(CC), .TURN_TIMEOUT(TT)) dut (
        .clk_3125KHz(clk_3125KHz), .rst_n(rst_n), .start(start), .node_flag(node_flag),
        .middle(middle), .lf_m1_a(lf_m1_a), .lf_m1_b(lf_m1_b), .lf_m2_a(lf_m2_a),
        .lf_m2_b(lf_m2_b), .lf_dc1(lf_dc1), .lf_dc2(lf_dc2), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_cmd(cfg_cmd), .cfg_len(cfg_len), .m1_a(m1_a),
        .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b), .dc1(dc1), .dc2(dc2), .busy(busy),
        .done(done), .fault(fault), .step(step)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    task automatic write_cfg(input logic [3:0] addr, input logic [1:0] cmd);
        cfg_we = 1'b1; cfg_addr = addr; cfg_cmd = cmd;
        @(negedge clk_3125KHz);
        cfg_we = 1'b0;
    endtask

    task automatic start_route(input logic [4:0] len);
        start = 1'b1; cfg_len = len;
        @(negedge clk_3125KHz);
        start = 1'b0;
    endtask

    task automatic node_rise();
        node_flag = 1'b1;
        @(negedge clk_3125KHz);
    endtask

    task automatic count_center(output int n);
        n = 0;
        while (dc1 == 4'd9 && n < CC * 4) begin
            n++;
            @(negedge clk_3125KHz);
        end
    endtask

    task automatic pivot_exit();
        middle = 12'd100;
        @(negedge clk_3125KHz);
        middle = 12'd1500;
        @(negedge clk_3125KHz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk_3125KHz);
        checks++;
        if (bundle !== 12'h000) begin errors++; $display("FAIL reset_motors: got %h want 000", bundle); end
        checks++;
        if ({busy, done, fault, step} !== 7'd0) begin
            errors++; $display("FAIL reset_status: busy/done/fault/step got %b want 0", {busy, done, fault, step});
        end
        rst_n = 1'b1;
        @(negedge clk_3125KHz);
    endtask

    task automatic test_passthrough();
        write_cfg(4'd0, STRAIGHT);
        write_cfg(4'd1, STOP);
        start_route(5'd2);
        checks++;
        if (bundle !== LF_BUNDLE) begin errors++; $display("FAIL pass_bundle: got %h want %h", bundle, LF_BUNDLE); end
        checks++;
        if (busy !== 1'b1 || step !== 4'd0) begin errors++; $display("FAIL pass_start: busy %b step %0d want 1/0", busy, step); end
        lf_dc1 = 4'd5;
        @(negedge clk_3125KHz);
        checks++;
        if (dc1 !== 4'd5) begin errors++; $display("FAIL pass_latency: dc1 %0d want 5", dc1); end
        lf_dc1 = 4'd12;
        node_rise();
        checks++;
        if (step !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL pass_straight: step %0d busy %b want 1/1", step, busy); end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
        node_rise();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bundle !== 12'h000) begin
            errors++; $display("FAIL pass_stop: done %b busy %b motors %h want 1/0/000", done, busy, bundle);
        end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL pass_done_pulse: done %b want 0", done); end
    endtask

    task automatic test_left_turn();
        int n;
        write_cfg(4'd0, LEFT);
        start_route(5'd1);
        node_rise();
        node_flag = 1'b0;
        checks++;
        if (bundle !== CENTER_BUNDLE) begin errors++; $display("FAIL left_center: got %h want %h", bundle, CENTER_BUNDLE); end
        count_center(n);
        checks++;
        if (n != CC) begin errors++; $display("FAIL left_center_len: %0d cycles want %0d", n, CC); end
        checks++;
        if (bundle !== LEFT_BUNDLE) begin errors++; $display("FAIL left_pivot: got %h want %h", bundle, LEFT_BUNDLE); end
        pivot_exit();
        checks++;
        if (bundle !== LF_BUNDLE || step !== 4'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL left_return: motors %h step %0d busy %b want %h/1/1", bundle, step, busy, LF_BUNDLE);
        end
        node_rise();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL left_done: done %b want 1", done); end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
    endtask

    task automatic test_node_held();
        int n;
        write_cfg(4'd0, LEFT);
        write_cfg(4'd1, STOP);
        start_route(5'd2);
        node_rise();
        count_center(n);
        pivot_exit();
        repeat (3) @(negedge clk_3125KHz);
        checks++;
        if (step !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL held_no_event: step %0d busy %b want 1/1", step, busy); end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
        node_rise();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL held_done: done %b want 1", done); end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
    endtask

    task automatic test_cfg_guard();
        write_cfg(4'd0, STRAIGHT);
        write_cfg(4'd1, STOP);
        start_route(5'd2);
        write_cfg(4'd0, STOP);
        node_rise();
        checks++;
        if (step !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL guard_write_dropped: step %0d busy %b want 1/1", step, busy); end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
        node_rise();
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
        start_route(5'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL guard_len0: done %b busy %b want 1/0", done, busy); end
        @(negedge clk_3125KHz);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL guard_len0_after: done %b busy %b want 0/0", done, busy); end
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_cmd = STOP; start = 1'b1; cfg_len = 5'd3;
        @(negedge clk_3125KHz);
        cfg_we = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL guard_same_cycle_start: busy %b want 1", busy); end
        node_rise();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL guard_same_cycle_write: done %b want 1", done); end
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
    endtask

    task automatic test_timeout();
        int n;
        write_cfg(4'd0, RIGHT);
        start_route(5'd1);
        node_rise();
        node_flag = 1'b0;
        count_center(n);
        checks++;
        if (bundle !== RIGHT_BUNDLE) begin errors++; $display("FAIL right_pivot: got %h want %h", bundle, RIGHT_BUNDLE); end
        n = 0;
        while (!fault && n < TT * 4) begin
            n++;
            @(negedge clk_3125KHz);
        end
        checks++;
        if (n != TT) begin errors++; $display("FAIL timeout_len: %0d cycles want %0d", n, TT); end
        checks++;
        if (bundle !== 12'h000 || busy !== 1'b0) begin errors++; $display("FAIL timeout_outputs: motors %h busy %b want 000/0", bundle, busy); end
        repeat (3) @(negedge clk_3125KHz);
        checks++;
        if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: fault %b want 1", fault); end
        start_route(5'd1);
        checks++;
        if (fault !== 1'b0 || step !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL fault_restart: fault %b step %0d busy %b want 0/0/1", fault, step, busy);
        end
        node_rise();
        node_flag = 1'b0;
        count_center(n);
        middle = 12'd100;
        @(negedge clk_3125KHz);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bundle !== 12'h000 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_turn: motors %h busy %b want 000/0", bundle, busy); end
        @(negedge clk_3125KHz);
        rst_n = 1'b1;
        middle = 12'd1500;
        @(negedge clk_3125KHz);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_left_turn();
        test_node_held();
        test_cfg_guard();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/node_route_sequencer.md
Name: node_route_sequencer

Overview:
- Sits between the line-following block and the motor PWM stage.
- Holds a programmable route table with one turn command per node.
- Passes the line follower's motor commands through while tracking.
- On each detected node, takes over the motors and runs a centre-and-pivot turn, then hands control back; reports route completion or a turn fault.

Parameters:
DEPTH, 16, route table entries (addr width 4)
CENTER_CYCLES, 312500, forward-drive cycles to centre over a node (100 ms at 3.125 MHz)
TURN_TIMEOUT, 3125000, max cycles for the whole pivot (1 s)
THRESH_HI, 12'd1000, sensor value counted as "on line"
THRESH_LO, 12'd200, sensor value counted as "off line"
PIVOT_DC, 4'd8, duty for both wheels while pivoting
CENTER_DC, 4'd9, duty for both wheels while centring

Ports:
clk_3125KHz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins route from entry 0
node_flag  in  1  node-present level from line follower
middle  in  12  LFA middle sensor
lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b  in  1 each  line-follower direction commands
lf_dc1, lf_dc2  in  4 each  line-follower duty (left, right)
cfg_we  in  1  route table write strobe
cfg_addr  in  4  route table write address
cfg_cmd  in  2  00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 STOP
cfg_len  in  5  route length, 0..16, latched on start
m1_a, m1_b, m2_a, m2_b  out  1 each  motor direction (m1 = left wheel)
dc1, dc2  out  4 each  motor duty (left, right)
busy  out  1  route in progress
done  out  1  one-cycle pulse on route completion
fault  out  1  pivot timeout, sticky
step  out  4  index of next route entry

Behaviour:
- Reset (async, rst_n=0):
  - All motor outputs and duties are 0.
  - busy, done and fault are 0; step=0.
  - Every table entry is STOP; latched length is 0; state is IDLE.
- All outputs are registered: one cycle of latency from state or pass-through inputs.
- Node event: node_flag=1 while its registered previous value was 0. The previous-value register updates every cycle in every state, so a flag still high on return to FOLLOW is not a new event.
- States:
  - IDLE: motors 0. On start, latch cfg_len, set step=0 and clear fault. Go to FINISH if the length is 0, else to FOLLOW.
  - FOLLOW (busy=1): outputs copy the lf_* inputs. On a node event:
    - If step equals the length, go to FINISH.
    - Otherwise read entry[step]. STRAIGHT: step+1 and stay in FOLLOW. LEFT/RIGHT: step+1, clear the counter, latch the direction, go to CENTER. STOP: go to FINISH.
  - CENTER: m1_a=1, m1_b=0, m2_a=1, m2_b=0, both duties CENTER_DC. After CENTER_CYCLES cycles, clear the counter and go to PIVOT_OFF.
  - PIVOT_OFF / PIVOT_ON: both duties PIVOT_DC. LEFT drives m1 (0,1) and m2 (1,0); RIGHT drives m1 (1,0) and m2 (0,1).
    - PIVOT_OFF goes to PIVOT_ON when middle < THRESH_LO.
    - PIVOT_ON goes to FOLLOW when middle > THRESH_HI.
    - One counter runs across both states. If it reaches TURN_TIMEOUT, go to FAULT.
  - FINISH: motors 0, done=1 for exactly this cycle, then IDLE.
  - FAULT: motors 0, fault=1, busy=0. Stays until start (which restarts as from IDLE) or reset.
- Node events in CENTER and the pivot states are ignored.
- A start while busy=1 is ignored.
- cfg_we is accepted only when busy=0; writes while busy are dropped.
- A table write and a start in the same cycle: the write lands, and start uses the new cfg_len.
- Counters are 24-bit and saturate; they never wrap.
- cfg_len values above 16 are clamped to 16.
- Reset mid-turn: motors stop immediately (async) and state returns to IDLE.

Test Plan:
- Reset: rst_n low -> all motor outputs and dc 0, step=0, busy=0; assert rst_n low mid-PIVOT_ON -> outputs 0 in the same cycle.
- Pass-through: load len=2 {STRAIGHT, STOP}; start; lf_dc1=12, lf_dc2=7 -> dc1=12, dc2=7 one cycle later. First node event -> step=1, still following. Second node event -> done pulse one cycle, motors 0.
- LEFT turn: entry0=LEFT, len=1; node event -> CENTER for 312500 cycles at 9/9 forward. Then m1 (0,1), m2 (1,0) at 8/8. middle=100 then middle=1500 -> back to FOLLOW. Next node event (step=1=len) -> done.
- Timeout: RIGHT entry, middle held at 1500 after CENTER -> fault=1 exactly 3125000 cycles into the pivot, motors 0. start -> fault clears, step=0.
- Node flag held high: node_flag stays 1 across the entire turn -> no extra step increment on return to FOLLOW.
- Config guard: cfg_we while busy with entry0 changed -> table unchanged. len=0 start -> done next cycle, busy never 1.
